// File: rtl/wb_mem_2_ppfifo_if.sv
// rtl/wb_mem_2_ppfifo_if.sv - Wishbone master bus and ppfifo write-side bundle for wb_mem_2_ppfifo
// master modport (DMA side):
//   out o_mem_we/o_mem_stb/o_mem_cyc, o_mem_sel[3:0], o_mem_adr[31:0], o_mem_dat[31:0]
//   in  i_mem_dat[31:0], i_mem_ack, i_mem_int
//   in  i_ppfifo_rdy[1:0], i_ppfifo_size[23:0]
//   out o_ppfifo_act[1:0], o_ppfifo_stb, o_ppfifo_data[31:0]
// slave modport is the mirror image (memory arbiter + ppfifo side).
interface wb_mem_2_ppfifo_if;
  logic        o_mem_we;
  logic        o_mem_stb;
  logic        o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [31:0] i_mem_dat;
  logic        i_mem_ack;
  logic        i_mem_int;
  logic [1:0]  i_ppfifo_rdy;
  logic [1:0]  o_ppfifo_act;
  logic [23:0] i_ppfifo_size;
  logic        o_ppfifo_stb;
  logic [31:0] o_ppfifo_data;

  modport master (
    output o_mem_we, o_mem_stb, o_mem_cyc, o_mem_sel, o_mem_adr, o_mem_dat,
    output o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data,
    input  i_mem_dat, i_mem_ack, i_mem_int, i_ppfifo_rdy, i_ppfifo_size
  );

  modport slave (
    input  o_mem_we, o_mem_stb, o_mem_cyc, o_mem_sel, o_mem_adr, o_mem_dat,
    input  o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data,
    output i_mem_dat, i_mem_ack, i_mem_int, i_ppfifo_rdy, i_ppfifo_size
  );
endinterface

// File: rtl/wb_mem_2_ppfifo.sv
// rtl/wb_mem_2_ppfifo.sv - Wishbone DMA reader draining two host memory blocks into a ping-pong FIFO
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   debug[31:0]                  status snapshot (enable, bus, act, bank, state)
//   i_enable                     core enable
//   i_memory_N_base/size/ready   per-bank word base, word count, re-arm pulse
//   o_memory_N_count/finished/empty  per-bank remaining words and status
//   o_read_finished              one-cycle pulse per consumed block
//   bus                          Wishbone master + ppfifo write side (wb_mem_2_ppfifo_if.master)
module wb_mem_2_ppfifo #(
  parameter int MEM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [31:0]          debug,
  input  logic                 i_enable,
  input  logic [MEM_WIDTH-1:0] i_memory_0_base,
  input  logic [MEM_WIDTH-1:0] i_memory_0_size,
  input  logic                 i_memory_0_ready,
  output logic [MEM_WIDTH-1:0] o_memory_0_count,
  output logic                 o_memory_0_finished,
  output logic                 o_memory_0_empty,
  input  logic [MEM_WIDTH-1:0] i_memory_1_base,
  input  logic [MEM_WIDTH-1:0] i_memory_1_size,
  input  logic                 i_memory_1_ready,
  output logic [MEM_WIDTH-1:0] o_memory_1_count,
  output logic                 o_memory_1_finished,
  output logic                 o_memory_1_empty,
  output logic                 o_read_finished,
  wb_mem_2_ppfifo_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_BLOCK = 3'd1,
    READ_DATA = 3'd2,
    FINISHED  = 3'd3
  } state_t;

  state_t               state;
  logic [MEM_WIDTH-1:0] ptr0;
  logic [MEM_WIDTH-1:0] ptr1;
  logic [MEM_WIDTH-1:0] read_size;
  logic [23:0]          fifo_count;
  logic                 bank;
  logic                 memory_ready;
  logic                 mem_cyc;
  logic                 mem_stb;
  logic                 ppfifo_stb;
  logic [1:0]           ppfifo_act;
  logic [31:0]          ppfifo_data;
  logic                 read_finished;

  logic [MEM_WIDTH-1:0] count0;
  logic [MEM_WIDTH-1:0] count1;
  logic [MEM_WIDTH-1:0] cur_ptr;
  logic [MEM_WIDTH-1:0] cur_count;
  logic                 unused_int;

  assign count0    = (i_memory_0_size == '0) ? '0 : i_memory_0_size - ptr0;
  assign count1    = (i_memory_1_size == '0) ? '0 : i_memory_1_size - ptr1;
  assign cur_ptr   = bank ? ptr1 : ptr0;
  assign cur_count = bank ? count1 : count0;

  assign o_memory_0_count    = count0;
  assign o_memory_1_count    = count1;
  assign o_memory_0_finished = (count0 == '0) && (i_memory_0_size != '0);
  assign o_memory_1_finished = (count1 == '0) && (i_memory_1_size != '0);
  assign o_memory_0_empty    = (count0 == '0) || (i_memory_0_size == '0);
  assign o_memory_1_empty    = (count1 == '0) || (i_memory_1_size == '0);
  assign o_read_finished     = read_finished;

  assign bus.o_mem_we      = 1'b0;
  assign bus.o_mem_sel     = 4'hF;
  assign bus.o_mem_dat     = 32'h0;
  assign bus.o_mem_adr     = bank ? (i_memory_1_base + ptr1) : (i_memory_0_base + ptr0);
  assign bus.o_mem_cyc     = mem_cyc;
  assign bus.o_mem_stb     = mem_stb;
  assign bus.o_ppfifo_act  = ppfifo_act;
  assign bus.o_ppfifo_stb  = ppfifo_stb;
  assign bus.o_ppfifo_data = ppfifo_data;
  assign unused_int        = bus.i_mem_int;

  assign debug = {19'd0, state, bank, memory_ready, ppfifo_stb, ppfifo_act,
                  read_finished, bus.i_mem_ack, mem_stb, mem_cyc, i_enable};

  // Bank selection: bank 0 has priority; the choice is held until the
  // active bank has nothing left to read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank         <= 1'b0;
      memory_ready <= 1'b0;
    end else if (!memory_ready) begin
      if (count0 != '0) begin
        bank         <= 1'b0;
        memory_ready <= 1'b1;
      end else if (count1 != '0) begin
        bank         <= 1'b1;
        memory_ready <= 1'b1;
      end
    end else if (cur_count == '0) begin
      memory_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr0          <= '0;
      ptr1          <= '0;
      read_size     <= '0;
      fifo_count    <= '0;
      mem_cyc       <= 1'b0;
      mem_stb       <= 1'b0;
      ppfifo_stb    <= 1'b0;
      ppfifo_act    <= 2'b00;
      ppfifo_data   <= 32'h0;
      read_finished <= 1'b0;
    end else begin
      ppfifo_stb    <= 1'b0;
      read_finished <= 1'b0;
      case (state)
        IDLE: begin
          mem_cyc <= 1'b0;
          mem_stb <= 1'b0;
          if (i_enable) state <= GET_BLOCK;
        end
        GET_BLOCK: begin
          mem_cyc <= 1'b0;
          mem_stb <= 1'b0;
          if (memory_ready) begin
            read_size <= cur_count;
            if (bank) ptr1 <= '0;
            else      ptr0 <= '0;
            state <= READ_DATA;
          end else if (!i_enable) begin
            state <= IDLE;
          end
        end
        READ_DATA: begin
          if ((cur_ptr < read_size) && memory_ready) begin
            if (mem_stb && bus.i_mem_ack) begin
              // stb drops for one cycle after every ack, so each ack maps
              // to exactly one FIFO strobe.
              ppfifo_data <= bus.i_mem_dat;
              ppfifo_stb  <= 1'b1;
              fifo_count  <= fifo_count + 24'd1;
              mem_stb     <= 1'b0;
              if (bank) ptr1 <= ptr1 + 1'b1;
              else      ptr0 <= ptr0 + 1'b1;
            end else if ((ppfifo_act != 2'b00) && (fifo_count < bus.i_ppfifo_size)) begin
              mem_cyc <= 1'b1;
              mem_stb <= 1'b1;
            end else begin
              // Either no half is held, or the held half is full. Release is
              // one cycle after the final strobe so the word lands in it.
              mem_cyc <= 1'b0;
              mem_stb <= 1'b0;
              if (ppfifo_act != 2'b00) ppfifo_act <= 2'b00;
            end
          end else begin
            // Block done: flush a partially filled half, keep an empty one.
            mem_cyc <= 1'b0;
            mem_stb <= 1'b0;
            if ((ppfifo_act != 2'b00) && (fifo_count != 24'd0)) ppfifo_act <= 2'b00;
            state <= FINISHED;
          end
        end
        FINISHED: begin
          read_finished <= 1'b1;
          state         <= GET_BLOCK;
        end
        default: state <= IDLE;
      endcase

      // The FSM only ever releases a held half, so grabbing only when none is
      // held never collides with it.
      if (i_enable && (ppfifo_act == 2'b00) && (bus.i_ppfifo_rdy != 2'b00)) begin
        ppfifo_act <= bus.i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
        fifo_count <= 24'd0;
      end

      // Host re-arm (or an unused bank) wins over any same-cycle increment.
      if (i_memory_0_ready || (i_memory_0_size == '0)) ptr0 <= '0;
      if (i_memory_1_ready || (i_memory_1_size == '0)) ptr1 <= '0;
    end
  end

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// tb/tb_wb_mem_2_ppfifo.sv - self-checking bench for wb_mem_2_ppfifo
module tb_wb_mem_2_ppfifo;

  localparam int DRAIN = 6;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] s0;
    logic [31:0] b1;
    logic [31:0] s1;
    int          fsz;
    int          dly;
    int          exp_chunks;
    int          exp_fin;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] debug;
  logic        i_enable = 1'b0;
  logic [31:0] b0 = 32'h0, b1 = 32'h0, s0 = 32'h0, s1 = 32'h0;
  logic        r0 = 1'b0, r1 = 1'b0;
  logic [31:0] count0, count1;
  logic        fin0, fin1, emp0, emp1;
  logic        read_finished;

  int ack_delay = 0;
  int fsz = 0;
  int wcnt = 0;
  logic [1:0] rdy = 2'b11;
  logic [1:0] act_seen = 2'b00;
  int drain [2];

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];
  int n_fin, n_chunks, words_in_act;
  logic [1:0] prev_act, last_chunk_act;
  logic prev_stb, prev_ack;

  always #5 clk = ~clk;

  wb_mem_2_ppfifo_if bus ();

  wb_mem_2_ppfifo #(.MEM_WIDTH(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .debug               (debug),
    .i_enable            (i_enable),
    .i_memory_0_base     (b0),
    .i_memory_0_size     (s0),
    .i_memory_0_ready    (r0),
    .o_memory_0_count    (count0),
    .o_memory_0_finished (fin0),
    .o_memory_0_empty    (emp0),
    .i_memory_1_base     (b1),
    .i_memory_1_size     (s1),
    .i_memory_1_ready    (r1),
    .o_memory_1_count    (count1),
    .o_memory_1_finished (fin1),
    .o_memory_1_empty    (emp1),
    .o_read_finished     (read_finished),
    .bus                 (bus)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Words are delivered in bank order; each block fills halves of fz words
  // and a partial half is flushed at the end of its block.
  function automatic int model_chunks(input int sa, input int sb, input int fz);
    return (sa + fz - 1) / fz + (sb + fz - 1) / fz;
  endfunction

  // Wishbone slave: ack after ack_delay cycles of stb, data derived from address.
  always @(posedge clk) begin
    if (!(bus.o_mem_cyc && bus.o_mem_stb) || bus.i_mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign bus.i_mem_ack     = bus.o_mem_cyc && bus.o_mem_stb && (wcnt >= ack_delay);
  assign bus.i_mem_dat     = word_at(bus.o_mem_adr);
  assign bus.i_mem_int     = 1'b0;
  assign bus.i_ppfifo_size = fsz[23:0];
  assign bus.i_ppfifo_rdy  = rdy;

  // ppfifo write side: a half is busy while held and for DRAIN cycles after release.
  always @(posedge clk) begin
    if (!rst_n) begin
      rdy      <= 2'b11;
      act_seen <= 2'b00;
      drain[0] <= 0;
      drain[1] <= 0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (bus.o_ppfifo_act[h]) rdy[h] <= 1'b0;
        else if (act_seen[h]) drain[h] <= DRAIN;
        else if (drain[h] > 1) drain[h] <= drain[h] - 1;
        else if (drain[h] == 1) begin
          drain[h] <= 0;
          rdy[h]   <= 1'b1;
        end
      end
      act_seen <= bus.o_ppfifo_act;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic sample();
    if (bus.o_ppfifo_stb) begin
      check("strobe_act_onehot", 32'(bus.o_ppfifo_act == 2'b01 || bus.o_ppfifo_act == 2'b10), 32'd1);
      words_in_act++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_strobe: got data 0x%08h, expected no strobe", bus.o_ppfifo_data);
      end else begin
        check("strobe_data", bus.o_ppfifo_data, exp_q.pop_front());
      end
    end
    if (prev_act != 2'b00 && bus.o_ppfifo_act != prev_act) begin
      check("cyc_low_at_release", 32'(bus.o_mem_cyc), 32'd0);
      if (words_in_act > 0) begin
        n_chunks++;
        if (last_chunk_act != 2'b00) check("act_alternates", 32'(prev_act != last_chunk_act), 32'd1);
        last_chunk_act = prev_act;
      end
      words_in_act = 0;
    end
    if (prev_stb && !prev_ack) check("stb_held_until_ack", 32'(bus.o_mem_stb), 32'd1);
    if (read_finished) n_fin++;
    prev_act = bus.o_ppfifo_act;
    prev_stb = bus.o_mem_stb;
    prev_ack = bus.i_mem_ack;
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    rst_n = 1'b0;
    i_enable = 1'b0;
    r0 = 1'b0;
    r1 = 1'b0;
    b0 = v.b0; s0 = v.s0; b1 = v.b1; s1 = v.s1;
    fsz = v.fsz;
    ack_delay = v.dly;
    repeat (2) @(negedge clk);
    n_fin = 0; n_chunks = 0; words_in_act = 0;
    last_chunk_act = 2'b00; prev_act = 2'b00; prev_stb = 1'b0; prev_ack = 1'b0;
    rst_n = 1'b1;
    r0 = 1'b1;
    r1 = 1'b1;
    i_enable = 1'b1;
  endtask

  task automatic run_case(input vec_t v, input string tag);
    bit done;
    start(v);
    exp_q.delete();
    for (int i = 0; i < int'(v.s0); i++) exp_q.push_back(word_at(v.b0 + 32'(i)));
    for (int i = 0; i < int'(v.s1); i++) exp_q.push_back(word_at(v.b1 + 32'(i)));
    @(negedge clk);
    sample();
    r0 = 1'b0;
    r1 = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      sample();
      if (exp_q.size() == 0 && n_fin >= v.exp_fin) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d words outstanding and %0d finished pulses, expected 0 and %0d",
               tag, exp_q.size(), n_fin, v.exp_fin);
    end
    repeat (20) begin
      @(negedge clk);
      sample();
    end
    check({tag, "_chunks"},    32'(n_chunks), 32'(v.exp_chunks));
    check({tag, "_fin_pulses"}, 32'(n_fin),   32'(v.exp_fin));
    check({tag, "_count0"},    count0, 32'd0);
    check({tag, "_count1"},    count1, 32'd0);
    check({tag, "_finished0"}, 32'(fin0), 32'(v.s0 != 0));
    check({tag, "_finished1"}, 32'(fin1), 32'(v.s1 != 0));
    check({tag, "_empty0"},    32'(emp0), 32'd1);
    check({tag, "_empty1"},    32'(emp1), 32'd1);
    check({tag, "_cyc_idle"},  32'(bus.o_mem_cyc), 32'd0);
    check({tag, "_debug_hi"},  debug >> 13, 32'd0);
    check({tag, "_debug_en"},  32'(debug[0]), 32'd1);
  endtask

  vec_t tbl [6];
  vec_t v;

  initial begin
    bit found;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_cyc",    32'(bus.o_mem_cyc), 32'd0);
    check("rst_stb",    32'(bus.o_mem_stb), 32'd0);
    check("rst_we",     32'(bus.o_mem_we), 32'd0);
    check("rst_sel",    32'(bus.o_mem_sel), 32'hF);
    check("rst_dat",    bus.o_mem_dat, 32'd0);
    check("rst_adr",    bus.o_mem_adr, 32'd0);
    check("rst_act",    32'(bus.o_ppfifo_act), 32'd0);
    check("rst_pstb",   32'(bus.o_ppfifo_stb), 32'd0);
    check("rst_pdata",  bus.o_ppfifo_data, 32'd0);
    check("rst_fin",    32'(read_finished), 32'd0);
    check("rst_debug",  debug, 32'd0);
    check("rst_empty0", 32'(emp0), 32'd1);

    tbl[0] = '{32'h100, 32'd4,  32'h000, 32'd0, 512, 0, 1, 1};
    tbl[1] = '{32'h400, 32'd10, 32'h000, 32'd0, 4,   0, 3, 1};
    tbl[2] = '{32'h200, 32'd3,  32'h300, 32'd2, 512, 0, 2, 2};
    tbl[3] = '{32'h500, 32'd5,  32'h000, 32'd0, 8,   3, 1, 1};
    tbl[4] = '{32'h600, 32'd0,  32'h700, 32'd3, 2,   1, 2, 1};
    tbl[5] = '{32'h800, 32'd7,  32'h900, 32'd5, 3,   2, 5, 2};
    for (int k = 0; k < 6; k++) run_case(tbl[k], $sformatf("tbl%0d", k));

    for (int k = 0; k < 6; k++) begin
      v.b0  = 32'($urandom_range(0, 4095)) << 4;
      v.b1  = 32'($urandom_range(0, 4095)) << 4;
      v.s0  = 32'($urandom_range(0, 12));
      v.s1  = 32'($urandom_range(0, 12));
      v.fsz = int'($urandom_range(1, 6));
      v.dly = int'($urandom_range(0, 3));
      v.exp_chunks = model_chunks(int'(v.s0), int'(v.s1), v.fsz);
      v.exp_fin    = int'(v.s0 != 0) + int'(v.s1 != 0);
      run_case(v, $sformatf("rnd%0d", k));
    end

    // Reset while stb is high with 2 words left.
    v = '{32'hA00, 32'd6, 32'h0, 32'd0, 512, 1, 0, 0};
    start(v);
    @(negedge clk);
    r0 = 1'b0;
    r1 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.o_mem_stb && count0 == 32'd2) found = 1'b1;
    end
    check("midrst_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cyc",   32'(bus.o_mem_cyc), 32'd0);
    check("midrst_stb",   32'(bus.o_mem_stb), 32'd0);
    check("midrst_act",   32'(bus.o_ppfifo_act), 32'd0);
    check("midrst_pstb",  32'(bus.o_ppfifo_stb), 32'd0);
    check("midrst_pdata", bus.o_ppfifo_data, 32'd0);
    check("midrst_count", count0, 32'd6);
    check("midrst_state", 32'(debug[12:10]), 32'd0);
    check("midrst_ready", 32'(debug[8]), 32'd0);
    @(negedge clk);
    i_enable = 1'b0;
    rst_n = 1'b1;

    // Re-arm pulse on bank 0 coinciding with an ack.
    v = '{32'hB00, 32'd8, 32'h0, 32'd0, 512, 0, 0, 0};
    start(v);
    @(negedge clk);
    r0 = 1'b0;
    r1 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.o_mem_stb && bus.i_mem_ack && count0 == 32'd5) found = 1'b1;
    end
    check("rearm_reached", 32'(found), 32'd1);
    r0 = 1'b1;
    @(posedge clk);
    #1;
    check("rearm_ptr_cleared", count0, 32'd8);
    check("rearm_strobe",      32'(bus.o_ppfifo_stb), 32'd1);
    @(negedge clk);
    r0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (read_finished) found = 1'b1;
    end
    check("rearm_block_done", 32'(found), 32'd1);
    check("rearm_finished0",  32'(fin0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
